// File: rtl/dmem_bytelane.sv
// Byte-addressable data memory with RISC-V access sizes, sign/zero-extended loads,
// byte-lane stores, and a ready/valid request/response handshake with READ_LAT cycles of latency.
`timescale 1ns/1ps
module dmem_bytelane #(
    parameter int DEPTH    = 2048,
    parameter int READ_LAT = 1,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state;
    logic [1:0]  cnt;
    logic [31:0] pend_rdata;
    logic        pend_err;
    logic [31:0] mem [DEPTH];

    logic          accept;
    logic [1:0]    lane;
    logic [IW-1:0] idx;
    logic          oob, misalign, err;
    logic [31:0]   rword, ld_data, cap_rdata;
    logic [15:0]   sh;
    logic [3:0]    be;
    logic [31:0]   wd;

    assign req_ready = (state == S_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign lane      = req_addr[1:0];
    assign idx       = req_addr[IW+1:2];

    // Full upper-address compare so out-of-range addresses never alias into the array.
    assign oob      = req_addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH);
    assign misalign = (req_size == 2'd3) ||
                      (req_size == 2'd1 && req_addr[0]) ||
                      (req_size == 2'd2 && lane != 2'd0);
    assign err      = oob || misalign;

    always_comb begin
        rword = mem[idx];
        sh    = 16'(rword >> {lane, 3'b000});
        case (req_size)
            2'd0:    ld_data = req_unsigned ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'd1:    ld_data = req_unsigned ? {16'b0, sh}      : {{16{sh[15]}}, sh};
            default: ld_data = rword;
        endcase
        cap_rdata = (err || req_we) ? 32'b0 : ld_data;
    end

    // Replicate store data across lanes; the byte enables pick which lanes land.
    always_comb begin
        case (req_size)
            2'd0:    begin be = 4'b0001 << lane; wd = {4{req_wdata[7:0]}};  end
            2'd1:    begin be = 4'b0011 << lane; wd = {2{req_wdata[15:0]}}; end
            2'd2:    begin be = 4'b1111;         wd = req_wdata;            end
            default: begin be = 4'b0000;         wd = req_wdata;            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept && req_we && !err) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 2'd0;
            pend_rdata <= 32'b0;
            pend_err   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    if (READ_LAT > 1) begin
                        state      <= S_WAIT;
                        cnt        <= 2'(READ_LAT - 2);
                        pend_rdata <= cap_rdata;
                        pend_err   <= err;
                    end else begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= cap_rdata;
                        rsp_err   <= err;
                    end
                end
                S_WAIT: begin
                    if (cnt == 2'd0) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= pend_rdata;
                        rsp_err   <= pend_err;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                S_RESP: if (rsp_ready) begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= 32'b0;
                    rsp_err   <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_bytelane.sv
// Directed bench for dmem_bytelane: one instance at READ_LAT=1 and one at READ_LAT=3,
// a vector table of load/store transactions plus stall and mid-transaction reset sequences.
`timescale 1ns/1ps
module tb_dmem_bytelane;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid[2], req_ready[2], req_we[2], req_unsigned[2];
    logic        rsp_valid[2], rsp_ready[2], rsp_err[2];
    logic [31:0] req_addr[2], req_wdata[2], rsp_rdata[2];
    logic [1:0]  req_size[2];

    dmem_bytelane #(.DEPTH(2048), .READ_LAT(1), .ADDR_W(32)) u_lat1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

    dmem_bytelane #(.DEPTH(2048), .READ_LAT(3), .ADDR_W(32)) u_lat3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

    typedef struct {
        int          d;
        logic        we;
        logic [31:0] addr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    vec_t vq[$];
    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic add(input int d, input logic we, input logic [31:0] addr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] wd, input logic [31:0] rd, input logic err);
        vec_t v;
        v.d = d; v.we = we; v.addr = addr; v.sz = sz; v.uns = uns; v.wd = wd; v.rd = rd; v.err = err;
        vq.push_back(v);
    endtask

    task automatic drive(input int d, input logic we, input logic [31:0] addr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] wd);
        req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
        req_size[d] = sz; req_unsigned[d] = uns; req_wdata[d] = wd;
    endtask

    // One request with rsp_ready held high; k = edges after acceptance before rsp_valid shows.
    task automatic xact(input int d, input logic we, input logic [31:0] addr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int k);
        @(negedge clk);
        drive(d, we, addr, sz, uns, wd);
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        k = 0;
        while (!rsp_valid[d] && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        rd = rsp_rdata[d];
        er = rsp_err[d];
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          k;

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 0; req_we[d] = 0; req_addr[d] = 0; req_size[d] = 0;
            req_unsigned[d] = 0; req_wdata[d] = 0; rsp_ready[d] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst ready0", 32'(req_ready[0]), 0);
        check("rst ready1", 32'(req_ready[1]), 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("post-rst ready d%0d", d), 32'(req_ready[d]), 1);
            check($sformatf("post-rst rsp_valid d%0d", d), 32'(rsp_valid[d]), 0);
            check($sformatf("post-rst rdata d%0d", d), rsp_rdata[d], 0);
            check($sformatf("post-rst err d%0d", d), 32'(rsp_err[d]), 0);
        end

        //  d  we  addr          sz uns wdata         exp rdata     err
        add(0, 1, 32'h10,       2, 0, 32'hDEADBEEF, 32'h0,        0);
        add(0, 0, 32'h10,       2, 0, 32'h0,        32'hDEADBEEF, 0);
        add(0, 1, 32'h10,       2, 0, 32'h0,        32'h0,        0);
        add(0, 1, 32'h11,       0, 0, 32'hABCDEF80, 32'h0,        0);
        add(0, 0, 32'h11,       0, 0, 32'h0,        32'hFFFFFF80, 0);
        add(0, 0, 32'h11,       0, 1, 32'h0,        32'h00000080, 0);
        add(0, 0, 32'h10,       2, 1, 32'h0,        32'h00008000, 0);
        add(0, 1, 32'h20,       2, 0, 32'h11223344, 32'h0,        0);
        add(0, 1, 32'h22,       1, 0, 32'h1234A5A5, 32'h0,        0);
        add(0, 0, 32'h22,       1, 0, 32'h0,        32'hFFFFA5A5, 0);
        add(0, 0, 32'h22,       1, 1, 32'h0,        32'h0000A5A5, 0);
        add(0, 0, 32'h20,       2, 0, 32'h0,        32'hA5A53344, 0);
        add(0, 0, 32'h20,       1, 0, 32'h0,        32'h00003344, 0);
        add(0, 0, 32'h13,       2, 0, 32'h0,        32'h0,        1);
        add(0, 0, 32'h21,       1, 0, 32'h0,        32'h0,        1);
        add(0, 0, 32'h20,       3, 0, 32'h0,        32'h0,        1);
        add(0, 0, 32'h2000,     2, 0, 32'h0,        32'h0,        1);
        add(0, 1, 32'h0,        2, 0, 32'h12345678, 32'h0,        0);
        add(0, 1, 32'h2000,     2, 0, 32'hCAFEF00D, 32'h0,        1);
        add(0, 0, 32'h0,        2, 0, 32'h0,        32'h12345678, 0);
        add(0, 0, 32'h80000000, 2, 0, 32'h0,        32'h0,        1);
        add(0, 1, 32'h21,       1, 0, 32'h0000FFFF, 32'h0,        1);
        add(0, 0, 32'h20,       2, 0, 32'h0,        32'hA5A53344, 0);
        add(0, 1, 32'h1FFC,     2, 0, 32'h7F000000, 32'h0,        0);
        add(0, 1, 32'h1FFE,     0, 0, 32'h00000099, 32'h0,        0);
        add(0, 0, 32'h1FFC,     2, 0, 32'h0,        32'h7F990000, 0);
        add(0, 0, 32'h1FFF,     0, 0, 32'h0,        32'h0000007F, 0);
        add(1, 1, 32'h48,       2, 0, 32'h11111111, 32'h0,        0);
        add(1, 1, 32'h40,       2, 0, 32'h55667788, 32'h0,        0);
        add(1, 0, 32'h43,       0, 0, 32'h0,        32'h00000055, 0);
        add(1, 0, 32'h42,       1, 0, 32'h0,        32'h00005566, 0);
        add(1, 0, 32'h40,       0, 1, 32'h0,        32'h00000088, 0);
        add(1, 0, 32'h40,       0, 0, 32'h0,        32'hFFFFFF88, 0);
        add(1, 0, 32'h41,       1, 0, 32'h0,        32'h0,        1);

        foreach (vq[i]) begin
            xact(vq[i].d, vq[i].we, vq[i].addr, vq[i].sz, vq[i].uns, vq[i].wd, rd, er, k);
            check($sformatf("v%0d rdata", i), rd, vq[i].rd);
            check($sformatf("v%0d err", i), 32'(er), 32'(vq[i].err));
            check($sformatf("v%0d latency", i), k, (vq[i].d == 0) ? 0 : 2);
        end

        // Latency-3 load with the consumer stalling five cycles.
        @(negedge clk);
        drive(1, 0, 32'h40, 2, 0, 32'h0);
        rsp_ready[1] = 1'b0;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        k = 0;
        while (!rsp_valid[1] && k < 20) begin
            check("stall wait ready", 32'(req_ready[1]), 0);
            @(posedge clk); #1;
            k++;
        end
        check("stall latency", k, 2);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("stall c%0d valid", c), 32'(rsp_valid[1]), 1);
            check($sformatf("stall c%0d rdata", c), rsp_rdata[1], 32'h55667788);
            check($sformatf("stall c%0d err", c), 32'(rsp_err[1]), 0);
            check($sformatf("stall c%0d ready", c), 32'(req_ready[1]), 0);
            @(posedge clk); #1;
        end
        @(negedge clk); rsp_ready[1] = 1'b1;
        #1;
        check("handshake cycle ready", 32'(req_ready[1]), 0);
        check("handshake cycle valid", 32'(rsp_valid[1]), 1);
        @(posedge clk); #1;
        check("after handshake valid", 32'(rsp_valid[1]), 0);
        check("after handshake ready", 32'(req_ready[1]), 1);

        // Reset while a store waits for its response; a request shown during reset is ignored.
        @(negedge clk);
        drive(1, 1, 32'h44, 2, 0, 32'h0BADF00D);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        check("wait valid", 32'(rsp_valid[1]), 0);
        @(negedge clk);
        rst = 1'b1;
        drive(1, 1, 32'h48, 2, 0, 32'hEEEEEEEE);
        @(posedge clk); #1;
        check("in-rst valid", 32'(rsp_valid[1]), 0);
        check("in-rst ready", 32'(req_ready[1]), 0);
        @(negedge clk);
        rst = 1'b0;
        req_valid[1] = 1'b0;
        #1;
        check("rst release ready", 32'(req_ready[1]), 1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check($sformatf("post-abort c%0d valid", c), 32'(rsp_valid[1]), 0);
            check($sformatf("post-abort c%0d ready", c), 32'(req_ready[1]), 1);
        end
        xact(1, 0, 32'h44, 2, 0, 32'h0, rd, er, k);
        check("aborted store kept", rd, 32'h0BADF00D);
        check("aborted store latency", k, 2);
        xact(1, 0, 32'h48, 2, 0, 32'h0, rd, er, k);
        check("rst-time store ignored", rd, 32'h11111111);
        xact(0, 0, 32'h10, 2, 0, 32'h0, rd, er, k);
        check("mem kept over rst", rd, 32'h00008000);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/dmem_bytelane.md
# dmem_bytelane

Byte-addressable data memory for the core's load/store unit, replacing the word-only data memory. It adds RISC-V access sizes, sign/zero extension, and byte-lane stores. A ready/valid request/response handshake with configurable read latency lets the pipeline stall on memory. Misaligned and out-of-range accesses are reported instead of silently aliasing.

## Interface
- DEPTH, 2048: number of 32-bit words; power of two, ≥ 4.
- READ_LAT, 1: cycles from request acceptance to response; legal range 1..4.
- ADDR_W, 32: byte-address width.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  request was misaligned, illegal size, or out of range.

## Operation
- Storage: DEPTH × 32-bit array; word index = req_addr[ADDR_W-1:2]; lane = req_addr[1:0]. Array is not cleared by rst.
- Error conditions, evaluated at acceptance:
  - size 3
  - half with addr[0] = 1
  - word with addr[1:0] ≠ 0
  - word index ≥ DEPTH, comparing all upper address bits with no truncation
- An errored request never writes the array. Its response carries rsp_err = 1 and rsp_rdata = 0.
- Store, no error:
  - byte: writes lane addr[1:0] with wdata[7:0]
  - half: writes lanes addr[1:0] and addr[1:0]+1 with wdata[15:0], little-endian
  - word: writes all four lanes
  - Unwritten lanes keep their value.
- Load, no error: selects the lane(s), then sign- or zero-extends per req_unsigned. Word loads ignore req_unsigned.
- FSM states:
  - IDLE: req_ready = 1. On req_valid, the request is accepted at that edge. Go to WAIT if READ_LAT > 1, else RESP.
  - WAIT: down-counter loaded with READ_LAT-2 at acceptance. Go to RESP when the counter is 0, else decrement.
  - RESP: rsp_valid = 1. Hold rsp_rdata and rsp_err stable until rsp_ready. On rsp_ready, go to IDLE.
- One outstanding request. req_ready = 0 in WAIT and RESP, including the cycle rsp_ready is asserted; there is no same-cycle turnaround.
- Store commit and load array sampling both occur at the acceptance edge. Later WAIT cycles only delay the captured result.

## Timing
- Reset values: state IDLE, req_ready = 0 while rst = 1 and 1 the cycle after, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, counter 0.
- Accept at edge N → rsp_valid = 1 after edge N+READ_LAT-1, i.e. visible READ_LAT cycles after the request cycle.
- Minimum back-to-back throughput: one request per READ_LAT+1 cycles, with rsp_ready held high.
- Read-after-write: a load accepted at any edge after a store's acceptance edge returns the stored data.
- rst mid-transaction (WAIT or RESP):
  - returns to IDLE next edge
  - drops the pending response
  - a store already committed at acceptance remains in the array
- Requests presented while rst = 1 are not accepted.
- rsp_valid never deasserts without rsp_ready or rst.

## Test plan
- Store word 0xDEADBEEF at 0x10, then load word 0x10 (READ_LAT = 1) → rsp_valid one cycle after acceptance, rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- Store byte 0x80 at 0x11 over word 0x00000000, then LB 0x11 → 0xFFFFFF80; LBU 0x11 → 0x00000080; LW 0x10 → 0x00008000.
- SH 0xA5A5 at 0x22 over 0x11223344, then LH 0x22 → 0xFFFFA5A5; LW 0x20 → 0xA5A53344.
- LW at 0x13, LH at 0x21, size 3, and LW at 4*DEPTH → each rsp_err = 1, rsp_rdata = 0. A store at 4*DEPTH leaves word 0 unchanged; no aliasing.
- READ_LAT = 3, rsp_ready held low 5 cycles after rsp_valid:
  - rsp_valid rises 3 cycles after acceptance
  - data stable throughout the stall
  - req_ready = 0 until the cycle after the rsp handshake
- Assert rst in WAIT with a store pending response → rsp_valid never rises, next cycle IDLE with req_ready = 1, and a subsequent load returns the stored value.
